// File: rtl/apb_arb_pkg.sv
// Shared types and limits for the APB master arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Width of a requester index; kept at least 1 so a 2-requester build still has a bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick: one-hot grant plus index of the first active request after ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken this cycle.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int pos;

  // Scan from the slot after ptr, wrapping, and take the first active request
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters (round-robin), optional ACCESS timeout via APB_TIMEOUT_EN.
// Latency: req_valid cycle N -> PSELx N+1 -> PENABLE N+2 -> rsp_valid N+3 with zero-wait PREADY.
// Backpressure: req_ready pulses only when a request is latched; ACCESS stalls on PREADY (or aborts on timeout).
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         PSELx,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_WIDTH-1:0]        PADDR,
  output logic [DATA_WIDTH-1:0]        PWDATA,
  output logic [DATA_WIDTH/8-1:0]      PSTRB,
  input  logic [DATA_WIDTH-1:0]        PRDATA,
  input  logic                         PREADY,
  input  logic                         PSLVERR
);

  localparam int IDX_W  = idx_width(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX || TIMEOUT_CYCLES < 1 ||
      (DATA_WIDTH % 8) != 0) begin : g_bad_params
    $error("apb_master_arbiter: parameter out of range");
  end

  apb_arb_state_e state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   arb_ptr;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               take;
  logic               done;
  logic               tmo;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Count stalled ACCESS cycles; restarts whenever a transfer enters SETUP
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                          to_cnt <= '0;
    else if (state_nxt == SETUP)         to_cnt <= '0;
    else if (state == ACCESS && !PREADY) to_cnt <= to_cnt + CNT_W'(1);
  end
`endif

  // On completion the finishing requester becomes the pointer, so it drops to lowest priority
  assign arb_ptr = (state == IDLE) ? ptr : cur_idx;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (arb_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Next state plus take/complete/abort strobes for the current cycle
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          take      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done = 1'b1;
          if (arb_any) begin
            take      = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept pulse is held off while reset is asserted so every output reads 0 in reset
  assign req_ready = (take && !PRESET) ? arb_gnt : '0;

  // State, RR pointer and owner of the in-flight transfer
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_REQ - 1);
      cur_idx <= '0;
    end else begin
      state <= state_nxt;
      if (done || tmo) ptr     <= cur_idx;
      if (take)        cur_idx <= arb_idx;
    end
  end

  // APB request signals: control follows next state, payload latched at grant and held otherwise
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSELx   <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
    end else begin
      PSELx   <= (state_nxt != IDLE);
      PENABLE <= (state_nxt == ACCESS);
      if (take) begin
        PWRITE <= req_write[arb_idx];
        PADDR  <= req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        PWDATA <= req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        PSTRB  <= req_strb[int'(arb_idx)*STRB_W +: STRB_W];
      end
    end
  end

  // One-cycle registered response to the owner; data forced to 0 for writes and aborts
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (done || tmo) ? (NUM_REQ'(1) << cur_idx) : '0;
      rsp_err   <= tmo | (done & PSLVERR);
      rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with scoreboard queues for grants and responses.
// Latency: checks N+1/N+2/N+3 phase timing and back-to-back transfers.
// Backpressure: exercises PREADY wait states, reset mid-transfer and a stuck slave.
module tb_apb_master_arbiter;

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        PCLK;
  logic        PRESET;
  logic [3:0]  req_valid;
  logic [3:0]  req_write;
  logic [31:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0] req_strb;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;

  rsp_t       rsp_q[$];
  logic [3:0] gnt_q[$];

  apb_master_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[i]        = w;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]  = s;
  endtask

  task automatic drive_edge();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    PRESET    = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  // Monitor: every presented grant or response is matched against the next expected entry
  always @(negedge PCLK) begin
    rsp_t e;
    logic [3:0] g;
    if (req_ready !== 4'b0000) begin
      if (gnt_q.size() == 0) begin
        total++; bad++;
        $display("FAIL req_ready_unexpected act=%b exp=none", req_ready);
      end else begin
        g = gnt_q.pop_front();
        chk("req_ready", 64'(req_ready), 64'(g));
      end
    end
    if (rsp_valid !== 4'b0000) begin
      if (rsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_valid_unexpected act=%b exp=none", rsp_valid);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(e.vld));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err",   64'(rsp_err),   64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g;
    bit  nogap;
    bit  stable;
    int  pen_cnt;

    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_strb = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset state
    @(negedge PCLK);
    chk("rst_psel",    64'(PSELx), 0);
    chk("rst_penable", 64'(PENABLE), 0);
    chk("rst_paddr",   64'(PADDR), 0);
    chk("rst_rsp_vld", 64'(rsp_valid), 0);
    chk("rst_rsp_err", 64'(rsp_err), 0);
    chk("rst_rdata",   64'(rsp_rdata), 0);
    req_valid = 4'b0001;
    #1 chk("rst_req_ready", 64'(req_ready), 0);
    req_valid = '0;
    drive_edge();
    PRESET = 1'b0;

    // 1: single read from requester 0, zero wait
    drive_edge();
    PREADY = 1'b1; PRDATA = 32'hDEADBEEF; PSLVERR = 1'b0;
    set_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
    gnt_q.push_back(4'b0001);
    rsp_q.push_back({4'b0001, 32'hDEADBEEF, 1'b0});
    req_valid = 4'b0001;
    @(negedge PCLK);
    chk("t1_psel_n", 64'(PSELx), 0);
    drive_edge();
    req_valid = '0;
    @(negedge PCLK);
    chk("t1_psel_n1",  64'(PSELx), 1);
    chk("t1_pen_n1",   64'(PENABLE), 0);
    chk("t1_paddr",    64'(PADDR), 64'h10);
    chk("t1_pwrite",   64'(PWRITE), 0);
    @(negedge PCLK);
    chk("t1_pen_n2",   64'(PENABLE), 1);
    @(negedge PCLK);
    chk("t1_rsp_n3",   64'(rsp_valid), 64'b0001);
    chk("t1_idle_n3",  64'(PSELx), 0);

    // 2: all four write continuously from reset, zero wait
    do_reset();
    PREADY = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h20 + i), 32'h1000_0000 + i, 4'hF);
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
    rsp_q.push_back({4'b0001, 32'h0, 1'b0}); rsp_q.push_back({4'b0010, 32'h0, 1'b0});
    rsp_q.push_back({4'b0100, 32'h0, 1'b0}); rsp_q.push_back({4'b1000, 32'h0, 1'b0});
    rsp_q.push_back({4'b0001, 32'h0, 1'b0});
    drive_edge();
    req_valid = 4'b1111;
    nogap = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge PCLK);
      if (k >= 1 && PSELx !== 1'b1) nogap = 1'b0;
      if (k % 2 == 1) begin
        g = ((k - 1) / 2) % 4;
        chk("t2_setup_paddr",  64'(PADDR),  64'(8'h20 + g));
        chk("t2_setup_pwdata", 64'(PWDATA), 64'(32'h1000_0000 + g));
        chk("t2_setup_pen",    64'(PENABLE), 0);
      end
      if (k == 8) begin
        drive_edge();
        req_valid = '0;
      end
    end
    chk("t2_no_gap", 64'(nogap), 1);
    @(negedge PCLK);
    chk("t2_idle_after", 64'(PSELx), 0);

    // 3: write from requester 2 with three wait states and a slave error
    drive_edge();
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h12345678;
    set_req(2, 1'b1, 8'h33, 32'hA5A5_0002, 4'b0110);
    gnt_q.push_back(4'b0100);
    rsp_q.push_back({4'b0100, 32'h0, 1'b1});
    req_valid = 4'b0100;
    @(negedge PCLK);
    drive_edge();
    req_valid = '0;
    @(negedge PCLK);
    stable = 1'b1;
    pen_cnt = 0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge PCLK);
      if (PENABLE === 1'b1) pen_cnt++;
      if ({PSELx, PWRITE, PADDR, PWDATA, PSTRB} !==
          {1'b1, 1'b1, 8'h33, 32'hA5A5_0002, 4'b0110}) stable = 1'b0;
      if (k == 4) begin
        drive_edge();
        PREADY = 1'b1; PSLVERR = 1'b1;
      end
    end
    drive_edge();
    PSLVERR = 1'b0;
    @(negedge PCLK);
    chk("t3_pen_cycles", 64'(pen_cnt), 4);
    chk("t3_p_stable",   64'(stable), 1);
    chk("t3_pen_after",  64'(PENABLE), 0);

    // 4: reset in ACCESS, then requester 0 wins over requester 1
    drive_edge();
    PREADY = 1'b0; PRDATA = 32'hCAFE0001;
    set_req(1, 1'b0, 8'h44, 32'h0, 4'h0);
    gnt_q.push_back(4'b0010);
    req_valid = 4'b0010;
    @(negedge PCLK);
    drive_edge();
    req_valid = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("t4_in_access", 64'(PENABLE), 1);
    #1 PRESET = 1'b1;
    #1;
    chk("t4_psel_async", 64'(PSELx), 0);
    chk("t4_pen_async",  64'(PENABLE), 0);
    set_req(0, 1'b0, 8'h50, 32'h0, 4'h0);
    req_valid = 4'b0011;
    @(negedge PCLK);
    chk("t4_ready_in_rst", 64'(req_ready), 0);
    drive_edge();
    PRESET = 1'b0; PREADY = 1'b1;
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010);
    rsp_q.push_back({4'b0001, 32'hCAFE0001, 1'b0});
    rsp_q.push_back({4'b0010, 32'hCAFE0001, 1'b0});
    @(negedge PCLK);
    drive_edge();
    req_valid = 4'b0010;
    @(negedge PCLK);
    chk("t4_paddr_req0", 64'(PADDR), 64'h50);
    @(negedge PCLK);
    drive_edge();
    req_valid = '0;
    repeat (4) @(negedge PCLK);

    // 5: slave never ready
    drive_edge();
    PREADY = 1'b0; PRDATA = 32'h0BADF00D;
    set_req(3, 1'b0, 8'h77, 32'h0, 4'h0);
    gnt_q.push_back(4'b1000);
`ifdef APB_TIMEOUT_EN
    rsp_q.push_back({4'b1000, 32'h0, 1'b1});
`endif
    req_valid = 4'b1000;
    @(negedge PCLK);
    drive_edge();
    req_valid = '0;
`ifdef APB_TIMEOUT_EN
    repeat (17) @(negedge PCLK);
    chk("t5_psel_last_access", 64'(PSELx), 1);
    @(negedge PCLK);
    chk("t5_psel_dropped", 64'(PSELx), 0);
    chk("t5_pen_dropped",  64'(PENABLE), 0);
`else
    repeat (100) @(negedge PCLK);
    chk("t5_psel_held", 64'(PSELx), 1);
    chk("t5_pen_held",  64'(PENABLE), 1);
    rsp_q.push_back({4'b1000, 32'h0BADF00D, 1'b0});
    drive_edge();
    PREADY = 1'b1;
`endif
    repeat (4) @(negedge PCLK);

    chk("rsp_q_drained", 64'(rsp_q.size()), 0);
    chk("gnt_q_drained", 64'(gnt_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
